multichannel_oversample_filter: RTL and testbench

//  Averages N_CH channel-tagged ADC streams, each over 2^os samples (block average, not sliding).

---
 rtl/multichannel_oversample_filter_pkg.sv | 35 +++
 rtl/multichannel_oversample_filter_if.sv | 22 ++
 rtl/multichannel_oversample_filter_channel.sv | 121 ++++++++++++
 rtl/multichannel_oversample_filter.sv | 81 ++++++++
 tb/tb_multichannel_oversample_filter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multichannel_oversample_filter_pkg.sv
// rtl/multichannel_oversample_filter_pkg.sv - shared state encodings, width functions and field-slice helpers for the oversample filter
package osf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_SAMPLE = 2'd2
    } osf_state_t;

    // Accumulator width: one sample plus headroom for 2^max_os additions.
    function automatic int osf_w_sum(input int w_data, input int max_os);
        return w_data + max_os;
    endfunction

    // Channel tag width; a single channel still needs one tag bit.
    function automatic int osf_w_ch(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Width of the latched (clamped) log2 ratio.
    function automatic int osf_w_os(input int max_os);
        return (max_os > 0) ? $clog2(max_os + 1) : 1;
    endfunction

    // LSB of channel k's field in the packed os_in bus.
    function automatic int osf_os_lsb(input int k, input int w_osm);
        return k * w_osm;
    endfunction

    // LSB of channel k's field in the packed cycle_delay_in bus.
    function automatic int osf_delay_lsb(input int k, input int w_ep);
        return k * w_ep;
    endfunction

endpackage

// File: rtl/multichannel_oversample_filter_if.sv
// rtl/multichannel_oversample_filter_if.sv - tagged sample stream in and tagged average stream out
interface multichannel_oversample_filter_if #(
    parameter int W_DATA = 18,
    parameter int W_CH   = 3
);
    logic signed [W_DATA-1:0] data_in;
    logic                     data_valid_in;
    logic [W_CH-1:0]          chan_in;
    logic signed [W_DATA-1:0] data_out;
    logic [W_CH-1:0]          chan_out;
    logic                     data_valid_out;

    modport master (
        output data_in, data_valid_in, chan_in,
        input  data_out, chan_out, data_valid_out
    );

    modport slave (
        input  data_in, data_valid_in, chan_in,
        output data_out, chan_out, data_valid_out
    );
endinterface

// File: rtl/multichannel_oversample_filter_channel.sv
// rtl/multichannel_oversample_filter_channel.sv - one channel's FSM, accumulator and averaging shift (OSF_ROUND_EN selects round-half-up)
module osf_channel
    import osf_pkg::*;
#(
    parameter int W_DATA = 18,
    parameter int W_EP   = 16,
    parameter int W_OSM  = 4,
    parameter int MAX_OS = 7,
    parameter int W_SUM  = 25
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     activate,
    input  logic [W_OSM-1:0]         os_cfg,
    input  logic [W_EP-1:0]          delay_cfg,
    input  logic                     sample_valid,
    input  logic signed [W_DATA-1:0] sample,
    output logic                     done,
    output logic signed [W_DATA-1:0] result
);

    localparam int W_OS = osf_w_os(MAX_OS);

    osf_state_t              state;
    logic [W_OS-1:0]         os_q;
    logic [W_OS-1:0]         os_clamped;
    logic signed [W_SUM-1:0] sum;
    logic signed [W_SUM-1:0] sum_next;
    logic [MAX_OS:0]         cnt;
    logic [MAX_OS:0]         cnt_next;
    logic [MAX_OS:0]         win_len;
    logic [W_EP-1:0]         dcnt;
    logic [W_EP-1:0]         dcnt_next;
    logic [W_EP-1:0]         dcnt_seen;
    logic                    win_last;

    // Window bookkeeping: clamp the requested ratio, next sum/count, and the completing-sample flag.
    always_comb begin
        os_clamped = (os_cfg > W_OSM'(MAX_OS)) ? W_OS'(MAX_OS) : os_cfg[W_OS-1:0];
        sum_next   = sum + W_SUM'(sample);
        cnt_next   = cnt + (MAX_OS + 1)'(1);
        win_len    = (MAX_OS + 1)'(1) << os_q;
        win_last   = (cnt_next == win_len);
        dcnt_next  = dcnt + W_EP'(1);
        dcnt_seen  = sample_valid ? dcnt_next : dcnt;
        done       = (state == ST_SAMPLE) && activate && sample_valid && win_last;
    end

`ifdef OSF_ROUND_EN
    logic signed [W_SUM:0] half;
    logic signed [W_SUM:0] sum_rnd;

    // Round half up: add half an LSB of the output before the floor shift; zero when os is 0.
    always_comb begin
        half    = ((W_SUM + 1)'(1) << os_q) >>> 1;
        sum_rnd = (W_SUM + 1)'(sum_next) + half;
        result  = W_DATA'(sum_rnd >>> os_q);
    end
`else
    // Floor average: arithmetic shift of the sum that includes the completing sample.
    always_comb begin
        result = W_DATA'(sum_next >>> os_q);
    end
`endif

    // Channel FSM: IDLE on deactivate, SAMPLE accumulates a window, DELAY discards settling samples.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_IDLE;
            os_q  <= '0;
            sum   <= '0;
            cnt   <= '0;
            dcnt  <= '0;
        end else if (!activate) begin
            state <= ST_IDLE;
            sum   <= '0;
            cnt   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SAMPLE;
                    os_q  <= os_clamped;
                    sum   <= '0;
                    cnt   <= '0;
                    dcnt  <= '0;
                end
                ST_SAMPLE: begin
                    if (sample_valid) begin
                        if (win_last) begin
                            sum  <= '0;
                            cnt  <= '0;
                            dcnt <= '0;
                            if (delay_cfg == '0) begin
                                os_q <= os_clamped;
                            end else begin
                                state <= ST_DELAY;
                            end
                        end else begin
                            sum <= sum_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dcnt_seen >= delay_cfg) begin
                        state <= ST_SAMPLE;
                        os_q  <= os_clamped;
                        dcnt  <= '0;
                    end else begin
                        dcnt  <= dcnt_seen;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multichannel_oversample_filter.sv
// rtl/multichannel_oversample_filter.sv - N_CH channel-tagged block averagers with one registered output (OSF_ROUND_EN selects rounding)
module multichannel_oversample_filter
    import osf_pkg::*;
#(
    parameter int W_DATA = 18,
    parameter int W_EP   = 16,
    parameter int W_OSM  = 4,
    parameter int MAX_OS = 7,
    parameter int N_CH   = 8
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CH*W_OSM-1:0]    os_in,
    input  logic [N_CH*W_EP-1:0]     cycle_delay_in,
    input  logic [N_CH-1:0]          activate_in,
    multichannel_oversample_filter_if.slave stream
);

    localparam int W_SUM = osf_w_sum(W_DATA, MAX_OS);
    localparam int W_CH  = osf_w_ch(N_CH);

    logic [N_CH-1:0]          ch_valid;
    logic [N_CH-1:0]          ch_done;
    logic signed [W_DATA-1:0] ch_result [N_CH];
    logic                     any_done;
    logic signed [W_DATA-1:0] sel_data;
    logic [W_CH-1:0]          sel_chan;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        // Route the sample only to the tagged channel; tags >= N_CH match nothing and are dropped.
        assign ch_valid[k] = stream.data_valid_in && (stream.chan_in == W_CH'(k));

        osf_channel #(
            .W_DATA (W_DATA),
            .W_EP   (W_EP),
            .W_OSM  (W_OSM),
            .MAX_OS (MAX_OS),
            .W_SUM  (W_SUM)
        ) u_ch (
            .clk_in       (clk_in),
            .reset_in     (reset_in),
            .activate     (activate_in[k]),
            .os_cfg       (os_in[osf_os_lsb(k, W_OSM) +: W_OSM]),
            .delay_cfg    (cycle_delay_in[osf_delay_lsb(k, W_EP) +: W_EP]),
            .sample_valid (ch_valid[k]),
            .sample       (stream.data_in),
            .done         (ch_done[k]),
            .result       (ch_result[k])
        );
    end

    // Pick the completing channel; one sample per cycle means at most one done bit is set.
    always_comb begin
        any_done = 1'b0;
        sel_data = '0;
        sel_chan = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_done[k]) begin
                any_done = 1'b1;
                sel_data = ch_result[k];
                sel_chan = W_CH'(k);
            end
        end
    end

    // Output register: pulse valid for one cycle, hold data and tag between pulses.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stream.data_valid_out <= 1'b0;
            stream.data_out       <= '0;
            stream.chan_out       <= '0;
        end else begin
            stream.data_valid_out <= any_done;
            if (any_done) begin
                stream.data_out <= sel_data;
                stream.chan_out <= sel_chan;
            end
        end
    end

endmodule

// File: tb/tb_multichannel_oversample_filter.sv
// tb/tb_multichannel_oversample_filter.sv - self-checking bench for multichannel_oversample_filter
`timescale 1ns/1ps
module tb_multichannel_oversample_filter;

    localparam int W_DATA = 18;
    localparam int W_EP   = 16;
    localparam int W_OSM  = 4;
    localparam int MAX_OS = 7;
    localparam int N_CH   = 5;
    localparam int W_CH   = 3;

`ifdef OSF_ROUND_EN
    localparam int T1_EXP  = 12;
    localparam int T2_EXP  = -2;
    localparam int T4_A    = 8;
    localparam int T4_B    = -1;
    localparam int T5_EXP  = 42;
`else
    localparam int T1_EXP  = 11;
    localparam int T2_EXP  = -3;
    localparam int T4_A    = 7;
    localparam int T4_B    = -2;
    localparam int T5_EXP  = 41;
`endif

    logic                   clk_in = 1'b0;
    logic                   reset_in;
    logic [N_CH*W_OSM-1:0]  os_in;
    logic [N_CH*W_EP-1:0]   cycle_delay_in;
    logic [N_CH-1:0]        activate_in;

    multichannel_oversample_filter_if #(.W_DATA(W_DATA), .W_CH(W_CH)) bus ();

    multichannel_oversample_filter #(
        .W_DATA (W_DATA),
        .W_EP   (W_EP),
        .W_OSM  (W_OSM),
        .MAX_OS (MAX_OS),
        .N_CH   (N_CH)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .os_in          (os_in),
        .cycle_delay_in (cycle_delay_in),
        .activate_in    (activate_in),
        .stream         (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    int cap_ch[$];
    int cap_d[$];

    // Behavioural model state: per-channel window contents and remaining discards.
    bit m_on   [N_CH];
    int m_sum  [N_CH];
    int m_cnt  [N_CH];
    int m_skip [N_CH];
    int m_os   [N_CH];
    bit e_valid = 1'b0;
    int e_data  = 0;
    int e_chan  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_clamp(input int os);
        return (os > MAX_OS) ? MAX_OS : os;
    endfunction

    // Mean of the window, rounded toward minus infinity (or half up when rounding is built in).
    function automatic int m_avg(input int sum, input int os);
        int d;
        int s;
        d = 1 << os;
        s = sum;
`ifdef OSF_ROUND_EN
        if (os > 0) s = sum + d / 2;
`endif
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int cfg_os(input int k);
        return m_clamp(int'(os_in[k*W_OSM +: W_OSM]));
    endfunction

    initial begin
        forever begin
            @(posedge clk_in or posedge reset_in);
            if (reset_in) begin
                for (int k = 0; k < N_CH; k++) begin
                    m_on[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_skip[k] = 0; m_os[k] = 0;
                end
                e_valid = 0; e_data = 0; e_chan = 0;
            end else begin
                e_valid = 0;
                for (int k = 0; k < N_CH; k++) begin
                    if (!activate_in[k]) begin
                        m_on[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_skip[k] = 0;
                    end else if (!m_on[k]) begin
                        m_on[k] = 1; m_sum[k] = 0; m_cnt[k] = 0; m_skip[k] = 0;
                        m_os[k] = cfg_os(k);
                    end else if (bus.data_valid_in && int'(bus.chan_in) == k) begin
                        if (m_skip[k] > 0) begin
                            m_skip[k]--;
                            if (m_skip[k] == 0) m_os[k] = cfg_os(k);
                        end else begin
                            m_sum[k] += int'($signed(bus.data_in));
                            m_cnt[k]++;
                            if (m_cnt[k] == (1 << m_os[k])) begin
                                e_valid = 1;
                                e_data  = m_avg(m_sum[k], m_os[k]);
                                e_chan  = k;
                                m_sum[k] = 0;
                                m_cnt[k] = 0;
                                m_skip[k] = int'(cycle_delay_in[k*W_EP +: W_EP]);
                                if (m_skip[k] == 0) m_os[k] = cfg_os(k);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (checking && !reset_in) begin
                chk("valid_out", int'(bus.data_valid_out), int'(e_valid));
                chk("data_out", int'($signed(bus.data_out)), e_data);
                chk("chan_out", int'(bus.chan_out), e_chan);
                if (bus.data_valid_out) begin
                    cap_ch.push_back(int'(bus.chan_out));
                    cap_d.push_back(int'($signed(bus.data_out)));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic smp(input int ch, input int v);
        bus.chan_in       = W_CH'(ch);
        bus.data_in       = W_DATA'(v);
        bus.data_valid_in = 1'b1;
        @(negedge clk_in);
        bus.data_valid_in = 1'b0;
    endtask

    task automatic set_ch(input int k, input int os, input int dly, input bit act);
        os_in[k*W_OSM +: W_OSM]         = W_OSM'(os);
        cycle_delay_in[k*W_EP +: W_EP]  = W_EP'(dly);
        activate_in[k]                  = act;
    endtask

    task automatic clear_caps();
        cap_ch.delete();
        cap_d.delete();
    endtask

    function automatic int cap_ch_at(input int i);
        return (i < cap_ch.size()) ? cap_ch[i] : -99;
    endfunction

    function automatic int cap_d_at(input int i);
        return (i < cap_d.size()) ? cap_d[i] : -999999;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in = '0; bus.chan_in = '0; bus.data_valid_in = 1'b0;
        os_in = '0; cycle_delay_in = '0; activate_in = '0;
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_valid", int'(bus.data_valid_out), 0);
        chk("rst_data", int'($signed(bus.data_out)), 0);
        chk("rst_chan", int'(bus.chan_out), 0);
        reset_in = 1'b0;
        checking = 1'b1;

        // 1: ch2 os=2, four samples
        set_ch(2, 2, 0, 1'b1); idle(2); clear_caps();
        smp(2, 10); smp(2, 11); smp(2, 12); smp(2, 13);
        idle(3);
        chk("t1_count", cap_d.size(), 1);
        chk("t1_chan", cap_ch_at(0), 2);
        chk("t1_data", cap_d_at(0), T1_EXP);

        // 2: negative floor/round on ch0 os=1
        set_ch(0, 1, 0, 1'b1); idle(2); clear_caps();
        smp(0, -3); smp(0, -2);
        idle(3);
        chk("t2_count", cap_d.size(), 1);
        chk("t2_data", cap_d_at(0), T2_EXP);

        // 3: ch1 os=0 delay=3, eight samples
        set_ch(1, 0, 3, 1'b1); idle(2); clear_caps();
        for (int i = 1; i <= 8; i++) smp(1, 100 + i);
        idle(3);
        chk("t3_count", cap_d.size(), 2);
        chk("t3_first", cap_d_at(0), 101);
        chk("t3_second", cap_d_at(1), 105);
        chk("t3_chan", cap_ch_at(1), 1);

        // 4: interleaved ch0 os=3 and ch3 os=1, out-of-range tags ignored
        set_ch(0, 3, 0, 1'b0); idle(1);
        set_ch(0, 3, 0, 1'b1); set_ch(3, 1, 0, 1'b1); idle(2); clear_caps();
        smp(0, 5); smp(3, 7); smp(5, 999); smp(0, -7); smp(3, 8);
        smp(0, 20); smp(0, 3); smp(7, -50); smp(3, -1); smp(0, 0);
        smp(0, 9); smp(3, -2); smp(0, -1); smp(0, 4);
        idle(3);
        chk("t4_count", cap_d.size(), 3);
        chk("t4_a_chan", cap_ch_at(0), 3);
        chk("t4_a_data", cap_d_at(0), T4_A);
        chk("t4_b_data", cap_d_at(1), T4_B);
        chk("t4_c_chan", cap_ch_at(2), 0);
        chk("t4_c_data", cap_d_at(2), 4);

        // 5: drop activation on the completing sample, then a clean window
        set_ch(1, 2, 0, 1'b0); idle(1);
        set_ch(1, 2, 0, 1'b1); idle(2); clear_caps();
        smp(1, 1); smp(1, 2); smp(1, 3);
        activate_in[1] = 1'b0;
        smp(1, 4);
        idle(2);
        activate_in[1] = 1'b1;
        idle(2);
        smp(1, 40); smp(1, 41); smp(1, 42); smp(1, 43);
        idle(3);
        chk("t5_count", cap_d.size(), 1);
        chk("t5_chan", cap_ch_at(0), 1);
        chk("t5_data", cap_d_at(0), T5_EXP);

        // 6: full-scale, os clamped to 7, async reset mid-window, rerun
        set_ch(4, 15, 0, 1'b1); idle(2); clear_caps();
        repeat (50) smp(4, 131071);
        #2 reset_in = 1'b1;
        #1;
        chk("t6_rst_valid", int'(bus.data_valid_out), 0);
        chk("t6_rst_data", int'($signed(bus.data_out)), 0);
        chk("t6_rst_chan", int'(bus.chan_out), 0);
        @(negedge clk_in);
        reset_in = 1'b0;
        idle(2);
        chk("t6_partial", cap_d.size(), 0);
        clear_caps();
        repeat (128) smp(4, 131071);
        idle(3);
        chk("t6_count", cap_d.size(), 1);
        chk("t6_chan", cap_ch_at(0), 4);
        chk("t6_data", cap_d_at(0), 131071);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
